core_memory_arbiter: RTL and testbench
======================================

Name: core_memory_arbiter

Overview:
- Shares the core's single memory bus between the instruction fetch port and the load/store data port.
- Fetch-side and data-side signals mirror the fetch stage interface: enable, address and a combinational busy that drops in the cycle data is valid.
- Data requests normally have priority; a streak limit guarantees fetch forward progress.
- Sits between the pipe stages and the core's external memory interface.

Parameters:
- DATA_STREAK_LIMIT, 4: max consecutive data grants while fetch is waiting; the next grant goes to fetch.
- TIMEOUT_CYCLES, 64: cycles without memAck before a transaction is aborted (only with the optional feature).

Ports:
- clk  in  1  core clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- fetchEnable  in  1  fetch request.
- fetchAddress  in  32  fetch address.
- fetchBusy  out  1  fetch not yet complete.
- fetchData  out  32  instruction, valid when fetchEnable && !fetchBusy.
- dataEnable  in  1  load/store request.
- dataWriteEnable  in  1  1 = store.
- dataByteSelect  in  4  byte lanes.
- dataAddress  in  32  data address.
- dataWriteData  in  32  store data.
- dataReadData  out  32  load data, valid when dataEnable && !dataBusy.
- dataBusy  out  1  data access not yet complete.
- memEnable  out  1  bus transaction active.
- memWriteEnable  out  1  bus store.
- memByteSelect  out  4  bus byte lanes.
- memAddress  out  32  bus address.
- memWriteData  out  32  bus store data.
- memReadData  in  32  bus read data, valid with memAck.
- memAck  in  1  one-cycle completion pulse.
- busError  out  1  one-cycle pulse on timeout abort.

Behaviour:
- FSM states: IDLE, FETCH, DATA.
- Reset (rst low, async): state IDLE, all mem* outputs 0, streak counter 0, busError 0.
- IDLE arbitration, evaluated each posedge:
  - dataEnable only: DATA.
  - fetchEnable only: FETCH.
  - Both, streak < DATA_STREAK_LIMIT: DATA, streak +1.
  - Both, streak == DATA_STREAK_LIMIT: FETCH, streak cleared.
  - Any FETCH grant clears the streak; a DATA grant with fetchEnable low leaves it unchanged.
- On grant, the requester's address, write enable, byte select and write data are captured into registers that drive mem*. memEnable is high from the cycle after the request is first seen until the ack cycle, inclusive. Fetch grants drive memWriteEnable=0 and memByteSelect=4'hF.
- FETCH/DATA exit on memAck: in that cycle the granted busy is 0 and fetchData/dataReadData = memReadData (combinational). Next state is IDLE, memEnable=0.
- Minimum latency is 2 cycles from request to busy low. Back-to-back accesses leave one idle bus cycle.
- Busy is combinational: each busy = its enable && !(granted && state matches && memAck). An ungranted requester stays busy.
- If the granted enable drops mid-transaction, the bus transaction still completes and the result is discarded. No abort on the bus.
- A memAck arriving in IDLE is ignored.
- Read data outputs are 0 when not in their ack cycle.
- Reset mid-transaction: immediate return to IDLE and memEnable=0. The outstanding ack is ignored.

Optional Feature:
- Macro: CORE_MEMORY_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each cycle in FETCH/DATA.
  - When it reaches TIMEOUT_CYCLES with no memAck: busError pulses 1 cycle, the granted busy drops that cycle with read data 32'hFFFFFFFF, and the FSM returns to IDLE.
- Undefined: no counter, busError tied 0, the FSM waits indefinitely.

Decomposition:
- Shared core package: FSM state encoding (IDLE=2'd0, FETCH=2'd1, DATA=2'd2), default fetch byte select 4'hF, timeout read value.
- One natural sub-module, core_memory_arbiter_priority: combinational grant decision plus the streak counter, so the fairness logic can be tested in isolation.

Test Plan:
- Fetch alone at 0x100, memAck 3 cycles after memEnable with 0x00000013 -> memEnable from cycle+1; fetchBusy low only in the ack cycle; fetchData=0x13.
- Store 0xDEADBEEF to 0x2000, byteSelect 4'b0011 -> memWriteEnable=1, memByteSelect=4'b0011, memWriteData=0xDEADBEEF held until ack; dataBusy low in the ack cycle.
- Fetch and data both held with 1-cycle acks, DATA_STREAK_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- dataEnable dropped two cycles after grant, ack arrives later -> bus completes; fetch is granted the cycle after the ack; no spurious dataReadData.
- rst pulsed low mid-FETCH -> memEnable=0 asynchronously; a later memAck is ignored; a fresh fetch completes normally.
- Macro defined, TIMEOUT_CYCLES=8, no ack -> busError pulse 8 cycles after grant; fetchData=0xFFFFFFFF, fetchBusy low that cycle; FSM back in IDLE.

Source files
------------

// File: rtl/core_memory_arbiter_pkg.sv
// rtl/core_memory_arbiter_pkg.sv - shared encodings for the core memory arbiter
package core_memory_arbiter_pkg;
  localparam logic [1:0]  STATE_IDLE     = 2'd0;
  localparam logic [1:0]  STATE_FETCH    = 2'd1;
  localparam logic [1:0]  STATE_DATA     = 2'd2;
  localparam logic [3:0]  FETCH_BYTE_SEL = 4'hF;
  localparam logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF;
endpackage

// File: rtl/core_memory_arbiter_priority.sv
// rtl/core_memory_arbiter_priority.sv - data-first grant decision with a streak limit for fetch progress
module core_memory_arbiter_priority #(
  parameter int DATA_STREAK_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic fetch_req,
  input  logic data_req,
  output logic grant_fetch,
  output logic grant_data
);
  localparam int SW = $clog2(DATA_STREAK_LIMIT + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          at_limit;

  assign at_limit = (streak_q == SW'(DATA_STREAK_LIMIT));

  // The streak only counts data grants that made a waiting fetch wait longer.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    streak_d    = streak_q;
    if (arb_en) begin
      if (data_req && fetch_req) begin
        if (at_limit) begin
          grant_fetch = 1'b1;
          streak_d    = '0;
        end else begin
          grant_data = 1'b1;
          streak_d   = streak_q + 1'b1;
        end
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (fetch_req) begin
        grant_fetch = 1'b1;
        streak_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak_q <= '0;
    else      streak_q <= streak_d;
  end
endmodule

// File: rtl/core_memory_arbiter.sv
// rtl/core_memory_arbiter.sv - shares the core memory bus between fetch and load/store ports
// Optional bus timeout abort: CORE_MEMORY_ARBITER_TIMEOUT_EN
module core_memory_arbiter
  import core_memory_arbiter_pkg::*;
#(
  parameter int DATA_STREAK_LIMIT = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchEnable,
  input  logic [31:0] fetchAddress,
  output logic        fetchBusy,
  output logic [31:0] fetchData,
  input  logic        dataEnable,
  input  logic        dataWriteEnable,
  input  logic [3:0]  dataByteSelect,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  output logic [31:0] dataReadData,
  output logic        dataBusy,
  output logic        memEnable,
  output logic        memWriteEnable,
  output logic [3:0]  memByteSelect,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  input  logic        memAck,
  output logic        busError
);
  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  bs_q, bs_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        arb_en, grant_fetch, grant_data;
  logic        timeout, done, fetch_done, data_done;
  logic [31:0] rdata;

  assign arb_en = (state_q == STATE_IDLE);

  core_memory_arbiter_priority #(
    .DATA_STREAK_LIMIT(DATA_STREAK_LIMIT)
  ) u_priority (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .fetch_req  (fetchEnable),
    .data_req   (dataEnable),
    .grant_fetch(grant_fetch),
    .grant_data (grant_data)
  );

`ifdef CORE_MEMORY_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  // timer_q holds the number of completed wait cycles, so the abort lands on the
  // TIMEOUT_CYCLES-th cycle spent waiting for an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           timer_q <= '0;
    else if (grant_fetch || grant_data) timer_q <= '0;
    else if (!arb_en)                   timer_q <= timer_q + 1'b1;
  end

  assign timeout  = !arb_en && !memAck && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign busError = timeout;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout  = 1'b0;
  assign busError = 1'b0;
`endif

  assign done       = !arb_en && (memAck || timeout);
  assign fetch_done = (state_q == STATE_FETCH) && done;
  assign data_done  = (state_q == STATE_DATA) && done;
  assign rdata      = timeout ? TIMEOUT_RDATA : memReadData;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    bs_d    = bs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (arb_en) begin
      if (grant_data) begin
        state_d = STATE_DATA;
        we_d    = dataWriteEnable;
        bs_d    = dataByteSelect;
        addr_d  = dataAddress;
        wdata_d = dataWriteData;
      end else if (grant_fetch) begin
        state_d = STATE_FETCH;
        we_d    = 1'b0;
        bs_d    = FETCH_BYTE_SEL;
        addr_d  = fetchAddress;
        wdata_d = '0;
      end
    end else if (done) begin
      state_d = STATE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STATE_IDLE;
      we_q    <= 1'b0;
      bs_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      bs_q    <= bs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign memEnable      = !arb_en;
  assign memWriteEnable = we_q;
  assign memByteSelect  = bs_q;
  assign memAddress     = addr_q;
  assign memWriteData   = wdata_q;

  // A requester that dropped its enable mid-transaction gets no result.
  assign fetchBusy    = fetchEnable && !fetch_done;
  assign dataBusy     = dataEnable && !data_done;
  assign fetchData    = (fetch_done && fetchEnable) ? rdata : '0;
  assign dataReadData = (data_done && dataEnable) ? rdata : '0;
endmodule

// File: tb/tb_core_memory_arbiter.sv
// tb/tb_core_memory_arbiter.sv - directed self-checking bench for core_memory_arbiter
module tb_core_memory_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEnable;
  logic [31:0] fetchAddress;
  logic        fetchBusy;
  logic [31:0] fetchData;
  logic        dataEnable;
  logic        dataWriteEnable;
  logic [3:0]  dataByteSelect;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [31:0] dataReadData;
  logic        dataBusy;
  logic        memEnable;
  logic        memWriteEnable;
  logic [3:0]  memByteSelect;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memAck;
  logic        busError;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  core_memory_arbiter #(
    .DATA_STREAK_LIMIT(4),
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetchEnable    (fetchEnable),
    .fetchAddress   (fetchAddress),
    .fetchBusy      (fetchBusy),
    .fetchData      (fetchData),
    .dataEnable     (dataEnable),
    .dataWriteEnable(dataWriteEnable),
    .dataByteSelect (dataByteSelect),
    .dataAddress    (dataAddress),
    .dataWriteData  (dataWriteData),
    .dataReadData   (dataReadData),
    .dataBusy       (dataBusy),
    .memEnable      (memEnable),
    .memWriteEnable (memWriteEnable),
    .memByteSelect  (memByteSelect),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData),
    .memAck         (memAck),
    .busError       (busError)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetchEnable = 0; fetchAddress = 0; dataEnable = 0; dataWriteEnable = 0;
    dataByteSelect = 0; dataAddress = 0; dataWriteData = 0; memReadData = 0; memAck = 0;
    cyc(); cyc(); #1;
    total++;
    if ({memEnable, memWriteEnable, memByteSelect, memAddress, memWriteData, busError, fetchBusy, dataBusy} !== 73'd0) begin
      bad++;
      $display("FAIL reset_outputs got en=%0b we=%0b bs=%h addr=%h wd=%h err=%0b fb=%0b db=%0b required all zero",
               memEnable, memWriteEnable, memByteSelect, memAddress, memWriteData, busError, fetchBusy, dataBusy);
    end
    cyc(); rst = 1'b1;
  endtask

  task automatic test_fetch_alone();
    cyc(); fetchEnable = 1; fetchAddress = 32'h100; #1;
    total++;
    if (memEnable !== 1'b0 || fetchBusy !== 1'b1) begin bad++; $display("FAIL fetch_req_cycle got en=%0b busy=%0b required 0/1", memEnable, fetchBusy); end
    cyc(); #1;
    total++;
    if (memEnable !== 1'b1 || memAddress !== 32'h100 || memWriteEnable !== 1'b0 || memByteSelect !== 4'hF) begin
      bad++; $display("FAIL fetch_bus got en=%0b addr=%h we=%0b bs=%h required 1/100/0/f", memEnable, memAddress, memWriteEnable, memByteSelect);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      total++;
      if (fetchBusy !== 1'b1 || fetchData !== 32'h0) begin bad++; $display("FAIL fetch_wait got busy=%0b data=%h required 1/0", fetchBusy, fetchData); end
    end
    cyc(); memAck = 1; memReadData = 32'h13; #1;
    total++;
    if (fetchBusy !== 1'b0 || fetchData !== 32'h13 || memEnable !== 1'b1) begin
      bad++; $display("FAIL fetch_ack got busy=%0b data=%h en=%0b required 0/13/1", fetchBusy, fetchData, memEnable);
    end
    cyc(); memAck = 0; fetchEnable = 0; #1;
    total++;
    if (memEnable !== 1'b0 || fetchData !== 32'h0) begin bad++; $display("FAIL fetch_after got en=%0b data=%h required 0/0", memEnable, fetchData); end
  endtask

  task automatic test_store();
    cyc(); dataEnable = 1; dataWriteEnable = 1; dataByteSelect = 4'b0011;
    dataAddress = 32'h2000; dataWriteData = 32'hDEADBEEF;
    cyc(); dataWriteData = 32'h12345678; dataByteSelect = 4'b1111; dataAddress = 32'h7777; #1;
    total++;
    if (memEnable !== 1'b1 || memWriteEnable !== 1'b1 || memByteSelect !== 4'b0011 || memAddress !== 32'h2000 || memWriteData !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_bus got en=%0b we=%0b bs=%h addr=%h wd=%h required 1/1/3/2000/deadbeef",
                      memEnable, memWriteEnable, memByteSelect, memAddress, memWriteData);
    end
    total++;
    if (dataBusy !== 1'b1) begin bad++; $display("FAIL store_wait got busy=%0b required 1", dataBusy); end
    cyc(); memAck = 1; #1;
    total++;
    if (dataBusy !== 1'b0 || memWriteData !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_ack got busy=%0b wd=%h required 0/deadbeef", dataBusy, memWriteData);
    end
    cyc(); memAck = 0; dataEnable = 0; dataWriteEnable = 0; #1;
    total++;
    if (memEnable !== 1'b0) begin bad++; $display("FAIL store_after got en=%0b required 0", memEnable); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_fetch;
    int n;
    exp_fetch = 10'b1000010000;
    n = 0;
    cyc(); fetchEnable = 1; fetchAddress = 32'h4000; dataEnable = 1; dataAddress = 32'h8000; dataByteSelect = 4'hF;
    for (int c = 0; c < 40 && n < 10; c++) begin
      cyc(); memAck = memEnable; memReadData = 32'hA000 + n; #1;
      if (memEnable) begin
        total++;
        if (memAddress !== (exp_fetch[n] ? 32'h4000 : 32'h8000)) begin
          bad++; $display("FAIL grant_order idx=%0d got addr=%h required %h", n, memAddress, exp_fetch[n] ? 32'h4000 : 32'h8000);
        end
        total++;
        if ((exp_fetch[n] ? dataBusy : fetchBusy) !== 1'b1) begin
          bad++; $display("FAIL ungranted_busy idx=%0d got 0 required 1", n);
        end
        n++;
      end
    end
    total++;
    if (n !== 10) begin bad++; $display("FAIL grant_count got %0d required 10", n); end
    cyc(); memAck = 0; fetchEnable = 0; dataEnable = 0;
    cyc();
  endtask

  task automatic test_drop_enable();
    cyc(); fetchEnable = 1; fetchAddress = 32'h4400; dataEnable = 1; dataAddress = 32'h300;
    cyc(); #1;
    total++;
    if (memEnable !== 1'b1 || memAddress !== 32'h300) begin bad++; $display("FAIL drop_grant got en=%0b addr=%h required 1/300", memEnable, memAddress); end
    cyc(); dataEnable = 0; #1;
    total++;
    if (dataBusy !== 1'b0 || memEnable !== 1'b1) begin bad++; $display("FAIL drop_hold got busy=%0b en=%0b required 0/1", dataBusy, memEnable); end
    cyc();
    cyc(); memAck = 1; memReadData = 32'hCAFE; #1;
    total++;
    if (dataReadData !== 32'h0 || fetchBusy !== 1'b1 || fetchData !== 32'h0) begin
      bad++; $display("FAIL drop_ack got rd=%h fb=%0b fd=%h required 0/1/0", dataReadData, fetchBusy, fetchData);
    end
    cyc(); memAck = 0; #1;
    total++;
    if (memEnable !== 1'b0) begin bad++; $display("FAIL drop_idle got en=%0b required 0", memEnable); end
    cyc(); memAck = 1; memReadData = 32'h55; #1;
    total++;
    if (memEnable !== 1'b1 || memAddress !== 32'h4400 || fetchData !== 32'h55 || fetchBusy !== 1'b0) begin
      bad++; $display("FAIL drop_fetch got en=%0b addr=%h fd=%h fb=%0b required 1/4400/55/0", memEnable, memAddress, fetchData, fetchBusy);
    end
    cyc(); memAck = 0; fetchEnable = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc(); fetchEnable = 1; fetchAddress = 32'h500;
    cyc(); #1;
    total++;
    if (memEnable !== 1'b1) begin bad++; $display("FAIL mid_active got en=%0b required 1", memEnable); end
    #1 rst = 1'b0; #1;
    total++;
    if (memEnable !== 1'b0) begin bad++; $display("FAIL mid_async got en=%0b required 0", memEnable); end
    cyc(); fetchEnable = 0; rst = 1'b1;
    cyc(); memAck = 1; memReadData = 32'hBAD; #1;
    total++;
    if (memEnable !== 1'b0 || fetchData !== 32'h0) begin bad++; $display("FAIL stale_ack got en=%0b fd=%h required 0/0", memEnable, fetchData); end
    cyc(); memAck = 0; #1;
    total++;
    if (memEnable !== 1'b0) begin bad++; $display("FAIL stale_ack_idle got en=%0b required 0", memEnable); end
    cyc(); fetchEnable = 1; fetchAddress = 32'h600;
    cyc(); memAck = 1; memReadData = 32'h0000_0093; #1;
    total++;
    if (memAddress !== 32'h600 || fetchData !== 32'h93 || fetchBusy !== 1'b0) begin
      bad++; $display("FAIL fresh_fetch got addr=%h fd=%h fb=%0b required 600/93/0", memAddress, fetchData, fetchBusy);
    end
    cyc(); memAck = 0; fetchEnable = 0;
    cyc();
  endtask

  task automatic test_timeout();
    int err_cycle;
    err_cycle = -1;
    cyc(); fetchEnable = 1; fetchAddress = 32'h700;
    for (int c = 1; c <= 20 && err_cycle < 0; c++) begin
      cyc(); #1;
      if (busError === 1'b1) begin
        err_cycle = c;
        total++;
        if (fetchData !== 32'hFFFF_FFFF || fetchBusy !== 1'b0) begin
          bad++; $display("FAIL timeout_data got fd=%h fb=%0b required ffffffff/0", fetchData, fetchBusy);
        end
      end
    end
`ifdef CORE_MEMORY_ARBITER_TIMEOUT_EN
    total++;
    if (err_cycle !== 8) begin bad++; $display("FAIL timeout_cycle got %0d required 8", err_cycle); end
    cyc(); fetchEnable = 0; #1;
    total++;
    if (memEnable !== 1'b0 || busError !== 1'b0) begin bad++; $display("FAIL timeout_idle got en=%0b err=%0b required 0/0", memEnable, busError); end
`else
    total++;
    if (err_cycle !== -1 || fetchBusy !== 1'b1 || memEnable !== 1'b1) begin
      bad++; $display("FAIL no_timeout got err_cycle=%0d fb=%0b en=%0b required -1/1/1", err_cycle, fetchBusy, memEnable);
    end
    cyc(); memAck = 1; memReadData = 32'h77; #1;
    total++;
    if (fetchData !== 32'h77) begin bad++; $display("FAIL late_ack got fd=%h required 77", fetchData); end
    cyc(); memAck = 0; fetchEnable = 0;
`endif
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_store();
    test_back_to_back();
    test_drop_enable();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
